io_responder: RTL and testbench
===============================

Name: io_responder

Overview:
- Responder end of the CPU's I/O bus: services CPU word reads/writes qualified by io_cs/io_rd/io_wr.
- Originates the CPU's intr request and completes the intr/int_ack handshake.
- Contains byte-addressable big-endian storage, a memory-mapped countdown timer, and an external request input.
- Sits beside data memory, driven by the CPU's Addr/D_OUT, and returns read data on the CPU's D_IOToInt input.

Parameters:
- ADDR_W, 12, byte-address width decoded from Addr; storage depth is 2**ADDR_W bytes.
- CNT_W, 16, timer counter width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- Addr  input  32  CPU byte address; only Addr[ADDR_W-1:2] is decoded, Addr[1:0] is ignored.
- D_in  input  32  write data from the CPU's D_OUT.
- io_cs  input  1  chip select.
- io_rd  input  1  read strobe.
- io_wr  input  1  write strobe.
- int_ack  input  1  interrupt acknowledge from the CPU.
- ext_req  input  1  synchronous, level-sensitive external interrupt source; a 0->1 edge is detected internally.
- D_out  output  32  read data to the CPU's D_IOToInt.
- intr  output  1  interrupt request to the CPU.

Behaviour:
- Address map, word index w = Addr[ADDR_W-1:2]:
  - TLOAD = last word minus 1 (0xFF8 at default ADDR_W).
  - STAT = last word (0xFFC).
  - All other words are storage.
- Storage write: when io_cs & io_wr at a rising edge with a storage address, bytes are written big-endian: mem[a]=D_in[31:24], mem[a+1]=D_in[23:16], mem[a+2]=D_in[15:8], mem[a+3]=D_in[7:0], with a = {w,2'b00}. Storage contents are not cleared by reset.
- Read path (combinational, zero latency):
  - D_out = {mem[a],mem[a+1],mem[a+2],mem[a+3]} when io_cs & io_rd.
  - At STAT, D_out = {29'b0, pending, timer_busy, intr}.
  - At TLOAD, D_out = {(32-CNT_W)'b0, count}.
  - D_out = 32'h0 whenever io_cs & io_rd is not asserted.
- io_rd & io_wr asserted together: the write occurs, and D_out shows the pre-write contents in that cycle.
- Writes to STAT are ignored.
- Timer:
  - A write to TLOAD loads count = D_in[CNT_W-1:0] and sets timer_busy=1.
  - While busy, count decrements by 1 per cycle. When count==1 at an edge, count becomes 0, timer_busy clears, and a timer event fires.
  - Loading 0 fires the event at the next edge (intr high one cycle after the write edge).
  - A load of N>0 raises intr exactly N cycles after the write edge.
  - Writing TLOAD while busy reloads the counter with no event.
- Event sources:
  - A timer event.
  - An ext_req rising edge (ext_req=1 now, registered ext_q=0).
  - Two events in the same cycle count as one.
- Interrupt FSM, states IDLE, REQ, ACK:
  - IDLE: an event moves to REQ, with intr=1 on the following cycle.
  - REQ: intr=1, held until int_ack=1 is seen at an edge; then ACK.
  - ACK: intr=0. When int_ack=0: if pending=1, clear pending and go to REQ; otherwise go to IDLE.
  - An event arriving in REQ or ACK sets pending=1. Only one pending event is kept; further events are dropped.
  - An event and int_ack at the same edge in REQ: go to ACK and set pending.
  - int_ack seen in IDLE is ignored.
- Reset, asynchronous and effective mid-operation:
  - State=IDLE, intr=0, pending=0, timer_busy=0, count=0, ext_q=0.
  - D_out follows the combinational rule above.
  - A reset during REQ drops the request with no replay.

Test Plan:
- Write 32'hDEADBEEF to 0x010, then read 0x010 and 0x013 -> D_out=32'hDEADBEEF both times. Read with io_cs=0 -> D_out=0.
- Write 32'h11223344 to 0x020, then read 0x020 -> D_out=32'h11223344. Reset, then read 0x020 -> data retained, intr=0, STAT reads 0.
- Write 5 to TLOAD at edge k -> intr=0 through edge k+4 and 1 after edge k+5. STAT reads 32'h2 while counting and 32'h1 once intr is high.
- intr high, pulse int_ack for 1 cycle -> intr low the cycle after the acknowledging edge, state IDLE, STAT=0.
- Raise ext_req while intr=1, then ack -> STAT shows pending=1 (32'h5). After int_ack drops, intr re-asserts once, then IDLE.
- Write 100 to TLOAD, then assert reset at count 50 -> intr stays 0 and no event ever fires. Write 0 to TLOAD -> intr=1 on the next cycle.

Source files
------------

// File: rtl/io_responder_if.sv
// CPU-side I/O bus between the CPU (master) and the I/O responder (slave):
// word access strobes, write/read data and the interrupt handshake.
interface io_responder_if;
    logic [31:0] Addr;
    logic [31:0] D_in;
    logic        io_cs;
    logic        io_rd;
    logic        io_wr;
    logic        int_ack;
    logic        ext_req;
    logic [31:0] D_out;
    logic        intr;

    modport master (
        output Addr,
        output D_in,
        output io_cs,
        output io_rd,
        output io_wr,
        output int_ack,
        output ext_req,
        input  D_out,
        input  intr
    );

    modport slave (
        input  Addr,
        input  D_in,
        input  io_cs,
        input  io_rd,
        input  io_wr,
        input  int_ack,
        input  ext_req,
        output D_out,
        output intr
    );
endinterface

// File: rtl/io_responder.sv
// I/O responder: big-endian byte storage, memory-mapped countdown timer,
// external request edge detector and the intr/int_ack request FSM.
module io_responder #(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          reset,
    io_responder_if.slave bus
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int WORD_W = ADDR_W - 2;
    localparam logic [WORD_W-1:0] STAT_WORD  = {WORD_W{1'b1}};
    localparam logic [WORD_W-1:0] TLOAD_WORD = {{(WORD_W-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    logic [7:0]        mem [0:DEPTH-1];

    state_t            state_r;
    state_t            state_s;
    logic              intr_r;
    logic              pending_r;
    logic              pending_s;
    logic              busy_r;
    logic [CNT_W-1:0]  count_r;
    logic              ext_q_r;

    logic [WORD_W-1:0] word_s;
    logic              is_stat_s;
    logic              is_tload_s;
    logic              rd_s;
    logic              wr_s;
    logic              mem_wr_s;
    logic              tload_wr_s;
    logic              timer_fire_s;
    logic              ext_rise_s;
    logic              event_s;
    logic [31:0]       rd_data_s;
    logic              unused_addr_s;

    assign word_s     = bus.Addr[ADDR_W-1:2];
    assign is_stat_s  = (word_s == STAT_WORD);
    assign is_tload_s = (word_s == TLOAD_WORD);
    assign rd_s       = bus.io_cs & bus.io_rd;
    assign wr_s       = bus.io_cs & bus.io_wr;
    assign mem_wr_s   = wr_s & ~is_stat_s & ~is_tload_s;
    assign tload_wr_s = wr_s & is_tload_s;

    // Byte lanes above ADDR_W and the in-word offset play no part in decoding.
    assign unused_addr_s = ^{bus.Addr[31:ADDR_W], bus.Addr[1:0]};

    // A count of 0 or 1 while busy fires on this edge; a reload takes priority.
    assign timer_fire_s = busy_r & (count_r <= CNT_ONE) & ~tload_wr_s;
    assign ext_rise_s   = bus.ext_req & ~ext_q_r;
    assign event_s      = timer_fire_s | ext_rise_s;

    // Storage write, big-endian; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_wr_s) begin
            mem[{word_s, 2'b00}] <= bus.D_in[31:24];
            mem[{word_s, 2'b01}] <= bus.D_in[23:16];
            mem[{word_s, 2'b10}] <= bus.D_in[15:8];
            mem[{word_s, 2'b11}] <= bus.D_in[7:0];
        end
    end

    // Zero-latency read mux; a simultaneous write shows the old contents.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        if (rd_s) begin
            if (is_stat_s) begin
                rd_data_s = {29'h0000_0000, pending_r, busy_r, intr_r};
            end else if (is_tload_s) begin
                rd_data_s = {{(32-CNT_W){1'b0}}, count_r};
            end else begin
                rd_data_s = {mem[{word_s, 2'b00}], mem[{word_s, 2'b01}],
                             mem[{word_s, 2'b10}], mem[{word_s, 2'b11}]};
            end
        end else begin
            rd_data_s = 32'h0000_0000;
        end
    end

    assign bus.D_out = rd_data_s;
    assign bus.intr  = intr_r;

    // Countdown timer: load on TLOAD write, decrement while busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= CNT_ZERO;
            busy_r  <= 1'b0;
        end else if (tload_wr_s) begin
            count_r <= bus.D_in[CNT_W-1:0];
            busy_r  <= 1'b1;
        end else if (timer_fire_s) begin
            count_r <= CNT_ZERO;
            busy_r  <= 1'b0;
        end else if (busy_r) begin
            count_r <= count_r - CNT_ONE;
        end
    end

    // External request history for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_q_r <= 1'b0;
        end else begin
            ext_q_r <= bus.ext_req;
        end
    end

    // Request FSM next state and single-slot pending bookkeeping.
    always_comb begin
        state_s   = state_r;
        pending_s = pending_r;
        case (state_r)
            ST_IDLE: begin
                if (event_s) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (event_s) begin
                    pending_s = 1'b1;
                end else begin
                    pending_s = pending_r;
                end
                if (bus.int_ack) begin
                    state_s = ST_ACK;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_ACK: begin
                if (bus.int_ack) begin
                    state_s   = ST_ACK;
                    pending_s = pending_r | event_s;
                end else if (pending_r | event_s) begin
                    // Replay one request; an event arriving now takes the freed slot.
                    state_s   = ST_REQ;
                    pending_s = pending_r & event_s;
                end else begin
                    state_s   = ST_IDLE;
                    pending_s = 1'b0;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                pending_s = 1'b0;
            end
        endcase
    end

    // FSM state, pending flag and registered interrupt request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            pending_r <= 1'b0;
            intr_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            pending_r <= pending_s;
            intr_r    <= (state_s == ST_REQ);
        end
    end

endmodule

// File: tb/tb_io_responder.sv
// Directed bench for io_responder: table of bus accesses plus hand-written
// timer, interrupt handshake and reset sequences.
module tb_io_responder;

    localparam logic [31:0] STAT_A  = 32'h0000_0FFC;
    localparam logic [31:0] TLOAD_A = 32'h0000_0FF8;

    logic clk;
    logic reset;
    int   vec_count;
    int   miss_count;

    io_responder_if bus();

    io_responder #(.ADDR_W(12), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        cs;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.io_cs = 1'b0;
        bus.io_rd = 1'b0;
        bus.io_wr = 1'b0;
        bus.Addr  = 32'h0;
        bus.D_in  = 32'h0;
    endtask

    task automatic wr_word(input logic [31:0] addr, input logic [31:0] data);
        bus.io_cs = 1'b1;
        bus.io_wr = 1'b1;
        bus.io_rd = 1'b0;
        bus.Addr  = addr;
        bus.D_in  = data;
        step();
        bus_idle();
    endtask

    task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        bus.io_cs = 1'b1;
        bus.io_rd = 1'b1;
        bus.io_wr = 1'b0;
        bus.Addr  = addr;
        #1;
        check(name, bus.D_out, exp);
        bus_idle();
        #1;
    endtask

    initial begin
        vec_count  = 0;
        miss_count = 0;
        reset       = 1'b1;
        bus.int_ack = 1'b0;
        bus.ext_req = 1'b0;
        bus_idle();

        //            cs    rd    wr    addr          din            expected D_out
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 32'h0000_0000};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0020, 32'h11223344, 32'h0000_0000};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 32'h11223344};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0022, 32'h0000_0000, 32'h11223344};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'hCAFEF00D, 32'hDEADBEEF};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hCAFEF00D};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, STAT_A,        32'hFFFF_FFFF, 32'h0000_0000};
        vecs[10] = '{1'b1, 1'b1, 1'b0, STAT_A,        32'h0000_0000, 32'h0000_0000};
        vecs[11] = '{1'b1, 1'b1, 1'b0, TLOAD_A,       32'h0000_0000, 32'h0000_0000};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h0000_0000, 32'h0000_0000};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 32'h0000_0FF4, 32'h0000_0000, 32'h0000_0000};

        // Word 0xFF4 holds garbage until written; give it a known value first.
        step();
        check("reset_intr", {31'h0, bus.intr}, 32'h0);
        rd_check("reset_stat", STAT_A, 32'h0);
        rd_check("reset_tload", TLOAD_A, 32'h0);
        #2 reset = 1'b0;
        step();
        wr_word(32'h0000_0FF4, 32'h0000_0000);

        for (int i = 0; i < 14; i++) begin
            bus.io_cs = vecs[i].cs;
            bus.io_rd = vecs[i].rd;
            bus.io_wr = vecs[i].wr;
            bus.Addr  = vecs[i].addr;
            bus.D_in  = vecs[i].din;
            #1;
            check($sformatf("vec%0d_dout", i), bus.D_out, vecs[i].exp_dout);
            check($sformatf("vec%0d_intr", i), {31'h0, bus.intr}, 32'h0);
            step();
        end
        bus_idle();

        // Storage survives reset; status does not.
        reset = 1'b1;
        #2 reset = 1'b0;
        rd_check("retain_020", 32'h0000_0020, 32'h11223344);
        check("retain_intr", {31'h0, bus.intr}, 32'h0);
        rd_check("retain_stat", STAT_A, 32'h0);
        step();

        // Load 5: intr stays low through edge k+4, rises after edge k+5.
        wr_word(TLOAD_A, 32'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t5_intr_%0d", i), {31'h0, bus.intr}, 32'h0);
            rd_check($sformatf("t5_stat_%0d", i), STAT_A, 32'h2);
            rd_check($sformatf("t5_cnt_%0d", i), TLOAD_A, 32'd5 - 32'(i));
            step();
        end
        check("t5_intr_fire", {31'h0, bus.intr}, 32'h1);
        rd_check("t5_stat_fire", STAT_A, 32'h1);

        // One-cycle acknowledge returns to idle.
        bus.int_ack = 1'b1;
        step();
        bus.int_ack = 1'b0;
        check("ack_intr", {31'h0, bus.intr}, 32'h0);
        rd_check("ack_stat", STAT_A, 32'h0);
        step();
        rd_check("idle_stat", STAT_A, 32'h0);
        bus.int_ack = 1'b1;
        step();
        bus.int_ack = 1'b0;
        step();
        check("idle_ack_ignored", {31'h0, bus.intr}, 32'h0);

        // Pending event while requesting replays exactly once.
        wr_word(TLOAD_A, 32'd0);
        rd_check("p_stat_load0", STAT_A, 32'h2);
        step();
        rd_check("p_stat_req", STAT_A, 32'h1);
        bus.ext_req = 1'b1;
        step();
        rd_check("p_stat_pend", STAT_A, 32'h5);
        bus.int_ack = 1'b1;
        step();
        bus.int_ack = 1'b0;
        check("p_ack_intr", {31'h0, bus.intr}, 32'h0);
        rd_check("p_ack_stat", STAT_A, 32'h4);
        step();
        check("p_replay_intr", {31'h0, bus.intr}, 32'h1);
        rd_check("p_replay_stat", STAT_A, 32'h1);
        bus.int_ack = 1'b1;
        step();
        bus.int_ack = 1'b0;
        step();
        rd_check("p_idle_stat", STAT_A, 32'h0);
        step();
        check("p_no_second_replay", {31'h0, bus.intr}, 32'h0);
        bus.ext_req = 1'b0;
        step();

        // Event coinciding with acknowledge becomes pending.
        wr_word(TLOAD_A, 32'd0);
        step();
        bus.ext_req = 1'b1;
        bus.int_ack = 1'b1;
        step();
        bus.ext_req = 1'b0;
        bus.int_ack = 1'b0;
        rd_check("co_stat", STAT_A, 32'h4);
        step();
        rd_check("co_replay_stat", STAT_A, 32'h1);
        bus.int_ack = 1'b1;
        step();
        bus.int_ack = 1'b0;
        step();
        rd_check("co_idle_stat", STAT_A, 32'h0);

        // Reload while busy restarts the countdown with no event.
        wr_word(TLOAD_A, 32'd10);
        step();
        step();
        step();
        wr_word(TLOAD_A, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rl_intr_%0d", i), {31'h0, bus.intr}, 32'h0);
            step();
        end
        check("rl_intr_fire", {31'h0, bus.intr}, 32'h1);
        bus.int_ack = 1'b1;
        step();
        bus.int_ack = 1'b0;
        step();

        // Reset in mid-count kills the timer.
        wr_word(TLOAD_A, 32'd100);
        for (int i = 0; i < 50; i++) step();
        rd_check("mid_cnt", TLOAD_A, 32'd50);
        reset = 1'b1;
        #1;
        check("mid_rst_intr", {31'h0, bus.intr}, 32'h0);
        rd_check("mid_rst_tload", TLOAD_A, 32'h0);
        #2 reset = 1'b0;
        begin
            int fired;
            fired = 0;
            for (int i = 0; i < 120; i++) begin
                step();
                if (bus.intr !== 1'b0) fired++;
            end
            check("mid_no_event", 32'(fired), 32'h0);
        end
        rd_check("mid_stat", STAT_A, 32'h0);
        wr_word(TLOAD_A, 32'd0);
        check("l0_intr_early", {31'h0, bus.intr}, 32'h0);
        step();
        check("l0_intr", {31'h0, bus.intr}, 32'h1);

        // Reset during a request drops it with no replay.
        reset = 1'b1;
        #2 reset = 1'b0;
        check("req_rst_intr", {31'h0, bus.intr}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("req_rst_hold_%0d", i), {31'h0, bus.intr}, 32'h0);
        end
        rd_check("req_rst_stat", STAT_A, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
